// File: rtl/prbs_pamn_gen.sv
// Multi-level PRBS symbol source: runtime-selectable Fibonacci LFSR advanced
// BPS steps per symbol, with seed load, Gray mapping, inversion and error inject.
module prbs_pamn_gen #(
    parameter int BPS   = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [30:0]      seed,
    input  logic [2:0]       poly_sel,
    input  logic             gray_en,
    input  logic             inv,
    input  logic             err_inj,
    output logic [BPS-1:0]   sym_out,
    output logic             sym_valid,
    output logic             period_pulse,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam logic [30:0] RST_STATE = 31'h7F;

    logic [30:0]    s;
    logic [30:0]    ref_s;
    logic [30:0]    msk;
    logic [30:0]    cur;
    logic [30:0]    ref_c;
    logic [30:0]    nxt;
    logic [30:0]    seed_m;
    logic [30:0]    load_v;
    logic [BPS-1:0] raw;
    logic [BPS-1:0] m;
    logic           nb;

    function automatic logic [30:0] sel_mask(input logic [2:0] sel);
        logic [30:0] r;
        unique case (sel)
            3'd0:    r = 31'h0000_007F;
            3'd1:    r = 31'h0000_01FF;
            3'd2:    r = 31'h0000_7FFF;
            3'd3:    r = 31'h007F_FFFF;
            default: r = 31'h7FFF_FFFF;
        endcase
        return r;
    endfunction

    function automatic logic tap_bit(input logic [30:0] v,
                                     input logic [2:0]  sel);
        logic r;
        unique case (sel)
            3'd0:    r = v[6]  ^ v[5];
            3'd1:    r = v[8]  ^ v[4];
            3'd2:    r = v[14] ^ v[13];
            3'd3:    r = v[22] ^ v[17];
            default: r = v[30] ^ v[27];
        endcase
        return r;
    endfunction

    // Clear bits above n-1; a state that collapses to zero is revived as all-ones.
    function automatic logic [30:0] fit(input logic [30:0] v,
                                        input logic [30:0] mk);
        logic [30:0] r;
        r = v & mk;
        if (r == 31'd0) r = mk;
        return r;
    endfunction

    always_comb begin
        msk    = sel_mask(poly_sel);
        cur    = fit(s, msk);
        ref_c  = fit(ref_s, msk);
        nxt    = cur;
        raw    = '0;
        nb     = 1'b0;
        for (int k = 0; k < BPS; k++) begin
            nb  = tap_bit(nxt, poly_sel);
            nxt = {nxt[29:0], nb} & msk;
            raw[BPS-1-k] = nb;
        end
        m = gray_en ? (raw ^ (raw >> 1)) : raw;
        if (inv)     m    = ~m;
        if (err_inj) m[0] = ~m[0];
        seed_m = seed & msk;
        load_v = (seed_m == 31'd0) ? msk : seed_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s            <= RST_STATE;
            ref_s        <= RST_STATE;
            sym_out      <= '0;
            sym_valid    <= 1'b0;
            period_pulse <= 1'b0;
            sym_cnt      <= '0;
        end else if (load) begin
            s            <= load_v;
            ref_s        <= load_v;
            sym_valid    <= 1'b0;
            period_pulse <= 1'b0;
            sym_cnt      <= '0;
        end else begin
            ref_s        <= ref_c;
            sym_valid    <= en;
            period_pulse <= en && (nxt == ref_c);
            if (en) begin
                s       <= nxt;
                sym_out <= m;
                sym_cnt <= sym_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                s <= cur;
            end
        end
    end

endmodule
